// File: rtl/transport_packetizer_pkg.sv
// Shared command codes, header layout and FSM state types for the transport packetizer.
package transport_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_CTRL  = 2'b01;
    localparam logic [1:0] CMD_AUDIO = 2'b10;

    localparam logic [1:0] HDR_TYPE_CTRL  = 2'b01;
    localparam logic [1:0] HDR_TYPE_AUDIO = 2'b10;

    typedef enum logic [2:0] {W_IDLE, W_HDR, W_DATA, W_PAD, W_COMMIT} wrState_t;
    typedef enum logic       {R_IDLE, R_SEND} rdState_t;

    function automatic logic [7:0] buildHeader(input logic [1:0] hdrType, input logic [3:0] seq);
        return {hdrType, 2'b00, seq};
    endfunction

endpackage

// File: rtl/transport_packetizer_ram.sv
// Simple dual-port byte RAM holding the packet ring; one write port, one registered read port.
module transport_packet_ram #(
    parameter int DEPTH = 68,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register only loads on a read, so the last byte is held between transfers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/transport_packetizer.sv
// Frames control/audio words into fixed-length headered packets in a slot ring and streams them out bytewise.
module transport_packetizer
    import transport_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int PAYLOAD_BYTES = 16,
    parameter int SLOTS         = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               cmd,
    input  logic [DATA_W-1:0]        data,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     send_req,
    output logic                     sending,
    output logic [7:0]               packet_out,
    output logic                     packet_valid,
    output logic                     packet_last,
    output logic [$clog2(SLOTS):0]   ready_count
);

    localparam int B     = DATA_W / 8;
    localparam int L     = PAYLOAD_BYTES + 1;
    localparam int SW    = $clog2(SLOTS);
    localparam int DEPTH = SLOTS * L;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = $clog2(L + 1);
    localparam int WBW   = (B > 1) ? $clog2(B) : 1;

    wrState_t          wState, wNext;
    rdState_t          rState, rNext;
    logic [SW:0]       wrPtr, rdPtr;
    logic [BW-1:0]     wrByte, rdByte;
    logic [WBW-1:0]    wordByte;
    logic [DATA_W-1:0] wordReg;
    logic              isCtrl, pendCtrl, audioOpen;
    logic [3:0]        seq;
    logic              ringFull, wordIn, accept;
    logic              ramWe, ramRe;
    logic [7:0]        ramWdata;
    logic [AW-1:0]     ramWaddr, ramRaddr;
    logic              pktValid, pktLast;

    // Slots between rdPtr and wrPtr are committed; the open slot sits at wrPtr itself.
    assign ringFull    = (wrPtr[SW] != rdPtr[SW]) && (wrPtr[SW-1:0] == rdPtr[SW-1:0]);
    assign ready_count = wrPtr - rdPtr;
    assign wordIn      = (cmd == CMD_CTRL) || (cmd == CMD_AUDIO);
    assign in_ready    = !reset && (wState == W_IDLE) && (audioOpen || !ringFull);
    assign accept      = in_ready && wordIn;
    assign ramWaddr    = AW'(wrPtr[SW-1:0]) * AW'(L) + AW'(wrByte);
    assign ramRaddr    = AW'(rdPtr[SW-1:0]) * AW'(L) + AW'(rdByte);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wState <= W_IDLE;
        else       wState <= wNext;
    end

    always_comb begin
        wNext    = wState;
        ramWe    = 1'b0;
        ramWdata = 8'h00;
        case (wState)
            W_IDLE: begin
                if (accept) begin
                    if (cmd == CMD_AUDIO) wNext = audioOpen ? W_DATA : W_HDR;
                    else                  wNext = audioOpen ? W_PAD  : W_HDR;
                end else if (flush && audioOpen) begin
                    wNext = W_PAD;
                end
            end
            // A control word queued behind a flush may find the ring full; hold until a slot frees.
            W_HDR: begin
                if (!ringFull) begin
                    ramWe    = 1'b1;
                    ramWdata = buildHeader(isCtrl ? HDR_TYPE_CTRL : HDR_TYPE_AUDIO, seq);
                    wNext    = W_DATA;
                end
            end
            W_DATA: begin
                ramWe    = 1'b1;
                ramWdata = wordReg[DATA_W-1 -: 8];
                if (wordByte == WBW'(B - 1)) begin
                    if (wrByte == BW'(L - 1)) wNext = W_COMMIT;
                    else if (isCtrl)          wNext = W_PAD;
                    else                      wNext = W_IDLE;
                end
            end
            W_PAD: begin
                ramWe = 1'b1;
                if (wrByte == BW'(L - 1)) wNext = W_COMMIT;
            end
            W_COMMIT: wNext = pendCtrl ? W_HDR : W_IDLE;
            default:  wNext = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr     <= '0;
            wrByte    <= '0;
            wordByte  <= '0;
            wordReg   <= '0;
            isCtrl    <= 1'b0;
            pendCtrl  <= 1'b0;
            audioOpen <= 1'b0;
            seq       <= '0;
        end else begin
            case (wState)
                W_IDLE: begin
                    if (accept) begin
                        wordReg  <= data;
                        wordByte <= '0;
                        isCtrl   <= (cmd == CMD_CTRL) && !audioOpen;
                        pendCtrl <= (cmd == CMD_CTRL) && audioOpen;
                    end
                end
                W_HDR: begin
                    if (!ringFull) begin
                        wrByte    <= wrByte + 1'b1;
                        audioOpen <= !isCtrl;
                    end
                end
                W_DATA: begin
                    wrByte   <= wrByte + 1'b1;
                    wordByte <= wordByte + 1'b1;
                    wordReg  <= wordReg << 8;
                end
                W_PAD: wrByte <= wrByte + 1'b1;
                W_COMMIT: begin
                    wrPtr     <= wrPtr + 1'b1;
                    seq       <= seq + 1'b1;
                    wrByte    <= '0;
                    audioOpen <= 1'b0;
                    isCtrl    <= pendCtrl;
                    pendCtrl  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rState <= R_IDLE;
        else       rState <= rNext;
    end

    always_comb begin
        rNext = rState;
        ramRe = 1'b0;
        case (rState)
            R_IDLE: if (send_req && ready_count != '0) rNext = R_SEND;
            R_SEND: begin
                ramRe = (rdByte != BW'(L));
                if (rdByte == BW'(L)) rNext = R_IDLE;
            end
            default: rNext = R_IDLE;
        endcase
    end

    // The extra cycle at rdByte==L drains the read register before the slot is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr    <= '0;
            rdByte   <= '0;
            pktValid <= 1'b0;
            pktLast  <= 1'b0;
        end else if (rState == R_SEND) begin
            rdByte   <= rdByte + 1'b1;
            pktValid <= (rdByte != BW'(L));
            pktLast  <= (rdByte == BW'(L - 1));
            if (rdByte == BW'(L)) rdPtr <= rdPtr + 1'b1;
        end else begin
            rdByte <= '0;
        end
    end

    assign sending      = (rState == R_SEND);
    assign packet_valid = pktValid;
    assign packet_last  = pktLast;

    transport_packet_ram #(.DEPTH(DEPTH), .AW(AW)) uRam (
        .clk   (clk),
        .reset (reset),
        .we    (ramWe),
        .waddr (ramWaddr),
        .wdata (ramWdata),
        .re    (ramRe),
        .raddr (ramRaddr),
        .rdata (packet_out)
    );

endmodule

// File: tb/tb_transport_packetizer.sv
// Scoreboard bench: a packet-level model queues expected bytes; a monitor checks the streamed output.
module tb_transport_packetizer;

    localparam int DATA_W = 16, PAYLOAD_BYTES = 16, SLOTS = 4;
    localparam int B = DATA_W / 8, L = PAYLOAD_BYTES + 1;

    logic              clk = 1'b0, reset = 1'b1;
    logic [1:0]        cmd = 2'b00;
    logic [DATA_W-1:0] data = '0;
    logic              flush = 1'b0, send_req = 1'b0;
    logic              in_ready, sending, packet_valid, packet_last;
    logic [7:0]        packet_out;
    logic [2:0]        ready_count;

    transport_packetizer #(.DATA_W(DATA_W), .PAYLOAD_BYTES(PAYLOAD_BYTES), .SLOTS(SLOTS)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .data(data), .in_ready(in_ready),
        .flush(flush), .send_req(send_req), .sending(sending), .packet_out(packet_out),
        .packet_valid(packet_valid), .packet_last(packet_last), .ready_count(ready_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: packets are byte lists; committed packets are appended to one flat stream.
    logic [7:0] expQ[$];
    logic [7:0] pl[$];
    bit         audioOpenM = 0;
    int         seqM = 0, expReady = 0;

    function automatic void commitPkt(input logic [1:0] typ);
        expQ.push_back({typ, 2'b00, 4'(seqM)});
        for (int i = 0; i < PAYLOAD_BYTES; i++)
            expQ.push_back(i < pl.size() ? pl[i] : 8'h00);
        pl.delete();
        seqM = (seqM + 1) % 16;
        expReady++;
    endfunction

    function automatic void modelWord(input logic [1:0] c, input logic [DATA_W-1:0] d);
        if (c == 2'b01 && audioOpenM) begin
            commitPkt(2'b10);
            audioOpenM = 0;
        end
        for (int i = B - 1; i >= 0; i--) pl.push_back(d[i*8 +: 8]);
        if (c == 2'b01) begin
            commitPkt(2'b01);
        end else begin
            audioOpenM = 1;
            if (pl.size() == PAYLOAD_BYTES) begin
                commitPkt(2'b10);
                audioOpenM = 0;
            end
        end
    endfunction

    // Monitor
    int         rxIdx = 0, reqCycle = -100;
    logic [7:0] lastHdr = 8'hxx, expByte;

    always @(negedge clk) begin
        if (!reset && packet_valid) begin
            if (rxIdx == 0) begin
                check("first byte latency", cyc, reqCycle + 2);
                lastHdr = packet_out;
            end
            if (expQ.size() == 0) begin
                failNow("unexpected output byte");
            end else begin
                expByte = expQ.pop_front();
                check("packet byte", packet_out, expByte);
            end
            check("packet_last", packet_last, (rxIdx == L - 1));
            if (rxIdx == L - 1) begin
                rxIdx = 0;
                expReady--;
            end else begin
                rxIdx++;
            end
        end
    end

    task automatic pushWord(input logic [1:0] c, input logic [DATA_W-1:0] d, output int acc);
        int t = 0;
        @(negedge clk);
        cmd = c;
        data = d;
        while (!in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            failNow("word accept timeout");
            cmd = 2'b00;
            acc = -1;
            return;
        end
        acc = cyc;
        modelWord(c, d);
        @(negedge clk);
        cmd = 2'b00;
    endtask

    task automatic measureLow(output int n);
        n = 0;
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic sendPkt();
        int t = 0;
        @(negedge clk);
        while ((ready_count == 0 || sending) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (ready_count == 0 || sending) begin
            failNow("send start timeout");
            return;
        end
        send_req = 1'b1;
        reqCycle = cyc;
        @(negedge clk);
        send_req = 1'b0;
        t = 0;
        while (sending && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sending) failNow("transfer end timeout");
    endtask

    task automatic doFlush();
        int t = 0;
        @(negedge clk);
        if (audioOpenM) begin
            while (!in_ready && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                failNow("flush wait timeout");
                return;
            end
            commitPkt(2'b10);
            audioOpenM = 0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic waitQuiet();
        repeat (2 * L + 8) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 reset = 1'b1;
        expQ.delete();
        pl.delete();
        audioOpenM = 0;
        seqM = 0;
        expReady = 0;
        rxIdx = 0;
        #1;
        check("reset sending", sending, 0);
        check("reset packet_valid", packet_valid, 0);
        check("reset packet_last", packet_last, 0);
        check("reset ready_count", ready_count, 0);
        check("reset in_ready", in_ready, 0);
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        int a, n, r;
        #3;
        check("rst in_ready", in_ready, 0);
        check("rst sending", sending, 0);
        check("rst packet_valid", packet_valid, 0);
        check("rst packet_last", packet_last, 0);
        check("rst ready_count", ready_count, 0);
        check("rst packet_out", packet_out, 8'h00);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check("in_ready after release", in_ready, 1);

        // Single control packet
        pushWord(2'b01, 16'hABCD, a);
        measureLow(n);
        check("ctrl word busy cycles", n, L + 1);
        check("ready_count after ctrl commit", ready_count, 1);
        sendPkt();
        check("ctrl header", lastHdr, 8'h40);
        check("ready_count after send", ready_count, 0);

        // Eight audio words fill one packet
        for (int i = 1; i <= 8; i++) begin
            pushWord(2'b10, 16'(i), a);
            if (i <= 2) begin
                measureLow(n);
                check(i == 1 ? "audio open busy cycles" : "audio word busy cycles", n, i == 1 ? B + 1 : B);
            end
        end
        waitQuiet();
        check("ready_count audio", ready_count, 1);
        sendPkt();
        check("audio header seq1", lastHdr, 8'h81);

        // Partial audio flushed by a control word
        for (int i = 0; i < 3; i++) pushWord(2'b10, 16'($urandom), a);
        pushWord(2'b01, 16'h1234, a);
        measureLow(n);
        check("flush+ctrl busy cycles", n, (PAYLOAD_BYTES - 3 * B) + 1 + L + 1);
        waitQuiet();
        check("ready_count two packets", ready_count, 2);
        sendPkt();
        check("flushed audio header", lastHdr, 8'h82);
        sendPkt();
        check("following ctrl header", lastHdr, 8'h43);

        // Full ring: a fifth word waits for a slot
        for (int i = 0; i < SLOTS; i++) pushWord(2'b01, 16'($urandom), a);
        waitQuiet();
        check("full ready_count", ready_count, SLOTS);
        check("full in_ready", in_ready, 0);
        fork
            pushWord(2'b01, 16'h5A5A, a);
            begin
                repeat (4) @(negedge clk);
                sendPkt();
            end
        join
        check("held word accept cycle", a, reqCycle + L + 2);
        waitQuiet();
        check("ring refilled", ready_count, SLOTS);
        for (int i = 0; i < SLOTS; i++) sendPkt();
        check("ring drained", ready_count, 0);

        // Reset in the middle of a transfer
        pushWord(2'b01, 16'hBEEF, a);
        waitQuiet();
        @(negedge clk);
        send_req = 1'b1;
        reqCycle = cyc;
        @(negedge clk);
        send_req = 1'b0;
        repeat (4) @(negedge clk);
        doReset();

        // Seq restarts at 0 and wraps after 16 commits
        for (int i = 0; i <= 16; i++) begin
            pushWord(2'b01, 16'($urandom), a);
            sendPkt();
            if (i == 0)  check("seq after reset", lastHdr, 8'h40);
            if (i == 15) check("seq 15", lastHdr, 8'h4F);
            if (i == 16) check("seq wrap", lastHdr, 8'h40);
        end

        // Randomized mix
        repeat (150) begin
            r = $urandom_range(0, 9);
            if (expReady >= SLOTS - 1) sendPkt();
            if (r <= 4)       pushWord(2'b10, 16'($urandom), a);
            else if (r <= 6)  pushWord(2'b01, 16'($urandom), a);
            else if (r == 7)  doFlush();
            else if (expReady > 0) sendPkt();
        end
        doFlush();
        for (int i = 0; i < SLOTS + 2 && expReady > 0; i++) sendPkt();
        waitQuiet();
        check("final ready_count", ready_count, 0);
        check("scoreboard empty", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global timeout");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
